// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: button-driven load/execute/capture sequencer for the 4-bit ALU.
// Synchronises, optionally debounces and edge-detects four push buttons,
// freezes operands/opcode per operation, and registers the ALU result/flags.
//
// Optional feature macro: ALU_SEQ_DEBOUNCE_EN
//   defined   -> per-button debounce counters (DB_CYCLES stable cycles, CNT_W bits)
//   undefined -> pulses come straight from the synchronised button level
//
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   btn_exec        raw button, start an operation
//   btn_clear       raw button, return to operand display
//   btn_mset        raw button, set M
//   btn_mclr        raw button, clear M
//   Num1_in[3:0]    operand A switches
//   Num2_in[3:0]    operand B switches
//   Control_in[7:0] opcode switches (bit 7 = signed)
//   alu_result[3:0] ALU result
//   alu_flags[3:0]  ALU flags {SF, ZF, CF, OF}
//   alu_num1[3:0]   operand A to ALU (live in IDLE, latched otherwise)
//   alu_num2[3:0]   operand B to ALU (live in IDLE, latched otherwise)
//   alu_ctrl[7:0]   opcode to ALU  (live in IDLE, latched otherwise)
//   M               ALU mode bit
//   isResult        display select, 1 in SHOW
//   busy            operation in flight (LOAD/EXEC/CAPTURE)
//   result_reg[3:0] captured result
//   flags_reg[3:0]  captured flags
//   op_count[7:0]   completed operations, saturating at 255

module alu_seq_ctrl #(
    parameter int DB_CYCLES = 100000,
    parameter int CNT_W     = 17
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       btn_exec,
    input  logic       btn_clear,
    input  logic       btn_mset,
    input  logic       btn_mclr,
    input  logic [3:0] Num1_in,
    input  logic [3:0] Num2_in,
    input  logic [7:0] Control_in,
    input  logic [3:0] alu_result,
    input  logic [3:0] alu_flags,
    output logic [3:0] alu_num1,
    output logic [3:0] alu_num2,
    output logic [7:0] alu_ctrl,
    output logic       M,
    output logic       isResult,
    output logic       busy,
    output logic [3:0] result_reg,
    output logic [3:0] flags_reg,
    output logic [7:0] op_count
);

    // Configuration sanity: the counter must be able to reach DB_CYCLES-1.
    if (DB_CYCLES < 1 || (2 ** CNT_W) <= DB_CYCLES) begin : g_bad_cfg
        $error("alu_seq_ctrl: need DB_CYCLES >= 1 and 2**CNT_W > DB_CYCLES");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_EXEC = 3'd2,
        S_CAPT = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    // Button bit order used throughout: {mclr, mset, clear, exec}
    localparam int B_EXEC  = 0;
    localparam int B_CLEAR = 1;
    localparam int B_MSET  = 2;
    localparam int B_MCLR  = 3;

    logic [3:0] w_btn_raw;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_level;
    logic [3:0] r_prev;
    logic [3:0] w_pulse;

    logic w_p_exec;
    logic w_p_clear;
    logic w_p_mset;
    logic w_p_mclr;

    state_t r_state;
    state_t w_state_nxt;

    logic       w_busy;
    logic       w_show;
    logic       w_latch;
    logic [3:0] r_num1;
    logic [3:0] r_num2;
    logic [7:0] r_ctrl;
    logic       r_m;
    logic [3:0] r_result;
    logic [3:0] r_flags;
    logic [7:0] r_op_count;

    //------------------------------------------------------------------
    // Button conditioning
    //------------------------------------------------------------------
    assign w_btn_raw = {btn_mclr, btn_mset, btn_clear, btn_exec};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    logic [CNT_W-1:0] r_cnt [4];
    logic [3:0]       r_level;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Counter runs only while the synchronised input disagrees with the
    // debounced level; any agreement restarts the stability window.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_level <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_level[i] <= ~r_level[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_level = r_level;
`else
    assign w_level = r_sync2;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign w_pulse   = w_level & ~r_prev;
    assign w_p_exec  = w_pulse[B_EXEC];
    assign w_p_clear = w_pulse[B_CLEAR];
    assign w_p_mset  = w_pulse[B_MSET];
    assign w_p_mclr  = w_pulse[B_MCLR];

    //------------------------------------------------------------------
    // Sequencer FSM
    //------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_p_exec) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: w_state_nxt = S_EXEC;
            S_EXEC: w_state_nxt = S_CAPT;
            S_CAPT: w_state_nxt = S_SHOW;
            S_SHOW: begin
                // clear has priority over a simultaneous exec
                if (w_p_clear) begin
                    w_state_nxt = S_IDLE;
                end else if (w_p_exec) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = 1'b0;
        w_show   = 1'b0;
        alu_num1 = r_num1;
        alu_num2 = r_num2;
        alu_ctrl = r_ctrl;
        unique case (r_state)
            S_IDLE: begin
                alu_num1 = Num1_in;
                alu_num2 = Num2_in;
                alu_ctrl = Control_in;
            end
            S_LOAD:  w_busy = 1'b1;
            S_EXEC:  w_busy = 1'b1;
            S_CAPT:  w_busy = 1'b1;
            S_SHOW:  w_show = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_show = 1'b0;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Datapath registers
    //------------------------------------------------------------------
    // Operands are frozen on the edge that enters LOAD, so the ALU already
    // sees the latched values throughout LOAD.
    assign w_latch = (w_state_nxt == S_LOAD);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_num1 <= '0;
            r_num2 <= '0;
            r_ctrl <= '0;
        end else if (w_latch) begin
            r_num1 <= Num1_in;
            r_num2 <= Num2_in;
            r_ctrl <= Control_in;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_result   <= '0;
            r_flags    <= '0;
            r_op_count <= '0;
        end else if (r_state == S_CAPT) begin
            r_result <= alu_result;
            r_flags  <= alu_flags;
            if (r_op_count != 8'hFF) begin
                r_op_count <= r_op_count + 8'd1;
            end
        end
    end

    // Mode changes are ignored while an operation is in flight; set wins.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_m <= 1'b0;
        end else if (!w_busy) begin
            if (w_p_mset) begin
                r_m <= 1'b1;
            end else if (w_p_mclr) begin
                r_m <= 1'b0;
            end
        end
    end

    assign M          = r_m;
    assign isResult   = w_show;
    assign busy       = w_busy;
    assign result_reg = r_result;
    assign flags_reg  = r_flags;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed self-checking bench for alu_seq_ctrl.
// Drives buttons/switches, models a small add/sub ALU, checks timing and state.

module tb_alu_seq_ctrl;

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int HOLD   = 6;
    localparam int PLAT   = 6;
    localparam int SETTLE = 10;
`else
    localparam int HOLD   = 1;
    localparam int PLAT   = 2;
    localparam int SETTLE = 2;
`endif

    logic       CLK;
    logic       RST;
    logic       btn_exec;
    logic       btn_clear;
    logic       btn_mset;
    logic       btn_mclr;
    logic [3:0] Num1_in;
    logic [3:0] Num2_in;
    logic [7:0] Control_in;
    logic [3:0] alu_result;
    logic [3:0] alu_flags;
    logic [3:0] alu_num1;
    logic [3:0] alu_num2;
    logic [7:0] alu_ctrl;
    logic       M;
    logic       isResult;
    logic       busy;
    logic [3:0] result_reg;
    logic [3:0] flags_reg;
    logic [7:0] op_count;

    int n_chk;
    int n_err;

    alu_seq_ctrl #(
        .DB_CYCLES(4),
        .CNT_W    (3)
    ) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .btn_exec  (btn_exec),
        .btn_clear (btn_clear),
        .btn_mset  (btn_mset),
        .btn_mclr  (btn_mclr),
        .Num1_in   (Num1_in),
        .Num2_in   (Num2_in),
        .Control_in(Control_in),
        .alu_result(alu_result),
        .alu_flags (alu_flags),
        .alu_num1  (alu_num1),
        .alu_num2  (alu_num2),
        .alu_ctrl  (alu_ctrl),
        .M         (M),
        .isResult  (isResult),
        .busy      (busy),
        .result_reg(result_reg),
        .flags_reg (flags_reg),
        .op_count  (op_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ALU model: opcode low nibble 1 = subtract, anything else = add
    logic [4:0] m_sum;
    logic       m_ov;
    always_comb begin
        m_sum = 5'd0;
        m_ov  = 1'b0;
        if (alu_ctrl[3:0] == 4'd1) begin
            m_sum = {1'b0, alu_num1} - {1'b0, alu_num2};
            m_ov  = (alu_num1[3] != alu_num2[3]) && (m_sum[3] != alu_num1[3]);
        end else begin
            m_sum = {1'b0, alu_num1} + {1'b0, alu_num2};
            m_ov  = (alu_num1[3] == alu_num2[3]) && (m_sum[3] != alu_num1[3]);
        end
        alu_result = m_sum[3:0];
        alu_flags  = {m_sum[3], (m_sum[3:0] == 4'd0), m_sum[4], m_ov};
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // mask bits: {mclr, mset, clear, exec}
    task automatic press(input logic [3:0] mask);
        {btn_mclr, btn_mset, btn_clear, btn_exec} = mask;
        repeat (HOLD) tick();
        {btn_mclr, btn_mset, btn_clear, btn_exec} = 4'b0000;
        repeat (SETTLE) tick();
    endtask

    initial begin
        n_chk      = 0;
        n_err      = 0;
        RST        = 1'b1;
        btn_exec   = 1'b0;
        btn_clear  = 1'b0;
        btn_mset   = 1'b0;
        btn_mclr   = 1'b0;
        Num1_in    = 4'd3;
        Num2_in    = 4'd0;
        Control_in = 8'h00;
        repeat (3) tick();
        RST = 1'b0;
        tick();

        // reset state and IDLE pass-through
        chk("rst_isResult", isResult, 0);
        chk("rst_busy", busy, 0);
        chk("rst_M", M, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_result", result_reg, 0);
        chk("rst_flags", flags_reg, 0);
        chk("idle_num1_3", alu_num1, 4'd3);
        Num1_in = 4'd9;
        #1;
        chk("idle_num1_9", alu_num1, 4'd9);

        // exec timing: 5 + 3
        Num1_in    = 4'd5;
        Num2_in    = 4'd3;
        Control_in = 8'h00;
        tick();
        btn_exec = 1'b1;
        for (int c = 0; c <= PLAT + 4; c++) begin
            if (c == HOLD) btn_exec = 1'b0;
            chk($sformatf("busy_c%0d", c), busy,
                32'((c >= PLAT + 1) && (c <= PLAT + 3)));
            chk($sformatf("isres_c%0d", c), isResult, 32'(c == PLAT + 4));
            if (c < PLAT + 4) tick();
        end
        chk("add_result", result_reg, 4'h8);
        chk("add_flags", flags_reg, 4'h9);
        chk("add_count", op_count, 8'd1);
        repeat (SETTLE) tick();

        // switches frozen in SHOW; exec+clear together -> clear wins
        Num1_in = 4'd1;
        Num2_in = 4'd1;
        #1;
        chk("show_num1_held", alu_num1, 4'd5);
        chk("show_num2_held", alu_num2, 4'd3);
        press(4'b0011);
        chk("clr_isResult", isResult, 0);
        chk("clr_busy", busy, 0);
        chk("clr_num1_live", alu_num1, 4'd1);
        chk("clr_count", op_count, 8'd1);

        // mset pulse lands in EXEC: dropped
        tick();
        btn_exec = 1'b1;
        for (int c = 0; c <= PLAT + 4; c++) begin
            if (c == HOLD) btn_exec = 1'b0;
            if (c == 2) btn_mset = 1'b1;
            if (c == 2 + HOLD) btn_mset = 1'b0;
            if (c == PLAT + 2) chk("exec_busy", busy, 1);
            tick();
        end
        repeat (SETTLE) tick();
        chk("mset_busy_M", M, 0);
        chk("op2_result", result_reg, 4'h2);
        chk("op2_flags", flags_reg, 4'h0);
        chk("op2_count", op_count, 8'd2);
        press(4'b0010);
        chk("clr2_isResult", isResult, 0);

        // M control in IDLE
        press(4'b1100);
        chk("mset_mclr_M", M, 1);
        press(4'b1000);
        chk("mclr_M", M, 0);

        // signed subtract 2 - 5, opcode latched
        Num1_in    = 4'd2;
        Num2_in    = 4'd5;
        Control_in = 8'h81;
        press(4'b0001);
        repeat (4) tick();
        chk("sub_isResult", isResult, 1);
        chk("sub_result", result_reg, 4'hD);
        chk("sub_flags", flags_reg, 4'hA);
        chk("sub_ctrl", alu_ctrl, 8'h81);
        Control_in = 8'h00;
        Num1_in    = 4'd7;
        Num2_in    = 4'd7;
        #1;
        chk("sub_ctrl_held", alu_ctrl, 8'h81);
        chk("sub_num1_held", alu_num1, 4'd2);

        // M change in SHOW leaves result alone
        press(4'b0100);
        chk("show_mset_M", M, 1);
        chk("show_mset_result", result_reg, 4'hD);

        // exec from SHOW re-latches switches: 7 + 7
        press(4'b0001);
        repeat (4) tick();
        chk("rex_isResult", isResult, 1);
        chk("rex_result", result_reg, 4'hE);
        chk("rex_flags", flags_reg, 4'h9);
        chk("rex_num1", alu_num1, 4'd7);
        chk("rex_count", op_count, 8'd4);
        press(4'b1000);
        chk("show_mclr_M", M, 0);
        press(4'b0010);

`ifdef ALU_SEQ_DEBOUNCE_EN
        // 3-cycle glitch gives no pulse
        tick();
        btn_mset = 1'b1;
        repeat (3) tick();
        btn_mset = 1'b0;
        repeat (10) tick();
        chk("glitch_M", M, 0);

        // 10-cycle press: one pulse, 6 cycles after first high sample
        tick();
        btn_exec = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 10) btn_exec = 1'b0;
            if (c == 6) chk("db_busy_c6", busy, 0);
            if (c == 7) chk("db_busy_c7", busy, 1);
            tick();
        end
        repeat (10) tick();
        chk("db_one_pulse", op_count, 8'd5);
        chk("db_isResult", isResult, 1);
        press(4'b0010);
`endif

        // saturation
        for (int i = 0; i < 256; i++) begin
            press(4'b0001);
            repeat (4) tick();
            press(4'b0010);
        end
        chk("sat_count", op_count, 8'd255);
        press(4'b0001);
        repeat (4) tick();
        chk("sat_hold", op_count, 8'd255);
        press(4'b0010);

        // reset asserted in CAPTURE
        Num1_in    = 4'd5;
        Num2_in    = 4'd3;
        Control_in = 8'h00;
        tick();
        btn_exec = 1'b1;
        for (int c = 0; c < PLAT + 3; c++) begin
            if (c == HOLD) btn_exec = 1'b0;
            tick();
        end
        btn_exec = 1'b0;
        chk("capt_busy", busy, 1);
        RST = 1'b1;
        #1;
        chk("ab_busy", busy, 0);
        chk("ab_isResult", isResult, 0);
        chk("ab_result", result_reg, 0);
        chk("ab_flags", flags_reg, 0);
        chk("ab_count", op_count, 0);
        tick();
        RST = 1'b0;
        repeat (3) tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_result", result_reg, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
